// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF challenge/response controller.
//   - state_t   : controller FSM states
//   - CH_W      : challenge width
//   - LFSR_TAPS : Galois feedback mask for the challenge generator
//   - SEED_ZERO_SUB : substitute for the all-zero (lock-up) seed
//   - lfsr_next : one step of the right-shift Galois LFSR
package puf_pkg;

   localparam int unsigned CH_W = 8;
   localparam logic [CH_W-1:0] LFSR_TAPS     = 8'hB8;
   localparam logic [CH_W-1:0] SEED_ZERO_SUB = 8'h01;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      LAUNCH,
      SAMPLE,
      ACC,
      DONE
   } state_t;

   // Right-shift Galois step; taps are folded in when the bit shifted out is 1.
   function automatic logic [CH_W-1:0] lfsr_next(input logic [CH_W-1:0] cur);
      return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer bringing the asynchronous PUF response into clk.
//   clk : system clock
//   rst : asynchronous active-high reset (clears both flops)
//   d   : asynchronous input
//   q   : synchronized output
module puf_resp_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Challenge/response controller for a feed-forward arbiter PUF. Generates
// challenges from an 8-bit LFSR, sequences PUF reset/launch, samples the
// synchronized response VOTES times per bit, majority-votes each bit into a
// response word and counts bits whose votes were not unanimous.
//   clk, rst      : clock, asynchronous active-high reset
//   start, seed   : request pulse and initial challenge (ignored while busy)
//   busy, done    : request in progress / one-cycle result-valid pulse
//   resp_word     : voted response, first evaluated bit in the MSB
//   unstable_cnt  : number of non-unanimous bits
//   puf_ch        : challenge applied to the PUF
//   puf_in        : launch edge into the mux chain
//   puf_rst       : reset for the PUF arbiter flops
//   puf_resp      : PUF response, asynchronous to clk
module puf_eval_ctrl
   import puf_pkg::*;
#(
   parameter int unsigned RESP_BITS  = 16,
   parameter int unsigned VOTES      = 5,
   parameter int unsigned RST_CYC    = 4,
   parameter int unsigned SETTLE_CYC = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic [CH_W-1:0]                    seed,
   output logic                               busy,
   output logic                               done,
   output logic [RESP_BITS-1:0]               resp_word,
   output logic [$clog2(RESP_BITS+1)-1:0]     unstable_cnt,
   output logic [CH_W-1:0]                    puf_ch,
   output logic                               puf_in,
   output logic                               puf_rst,
   input  logic                               puf_resp
);

   localparam int unsigned UW   = $clog2(RESP_BITS + 1);
   localparam int unsigned VW   = $clog2(VOTES + 1);
   localparam int unsigned BW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
   localparam int unsigned CMAX = (RST_CYC > SETTLE_CYC) ? ((RST_CYC > 2) ? RST_CYC : 2)
                                                         : ((SETTLE_CYC > 2) ? SETTLE_CYC : 2);
   localparam int unsigned CW   = $clog2(CMAX);

   state_t               state, state_n;
   logic [CW-1:0]        cyc_cnt, cyc_n;
   logic [VW-1:0]        vote_cnt, vote_n;
   logic [VW-1:0]        ones, ones_n, ones_sum;
   logic [BW-1:0]        bit_idx, bit_n;
   logic [RESP_BITS-1:0] shreg, sh_n, word_n;
   logic [UW-1:0]        unst, unst_n, ucnt_n;
   logic [CH_W-1:0]      lfsr_n;
   logic                 busy_n, done_n, puf_rst_n, puf_in_n;
   logic                 maj;
   logic                 resp_sync;

   puf_resp_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (puf_resp),
      .q   (resp_sync)
   );

   // State, datapath and output registers; outputs follow the current state one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cyc_cnt      <= '0;
         vote_cnt     <= '0;
         ones         <= '0;
         bit_idx      <= '0;
         shreg        <= '0;
         unst         <= '0;
         puf_ch       <= '0;
         resp_word    <= '0;
         unstable_cnt <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         puf_in       <= 1'b0;
         puf_rst      <= 1'b1;
      end else begin
         state        <= state_n;
         cyc_cnt      <= cyc_n;
         vote_cnt     <= vote_n;
         ones         <= ones_n;
         bit_idx      <= bit_n;
         shreg        <= sh_n;
         unst         <= unst_n;
         puf_ch       <= lfsr_n;
         resp_word    <= word_n;
         unstable_cnt <= ucnt_n;
         busy         <= busy_n;
         done         <= done_n;
         puf_in       <= puf_in_n;
         puf_rst      <= puf_rst_n;
      end
   end

   // Next-state and next-value logic.
   always_comb begin
      state_n   = state;
      cyc_n     = cyc_cnt;
      vote_n    = vote_cnt;
      ones_n    = ones;
      bit_n     = bit_idx;
      sh_n      = shreg;
      unst_n    = unst;
      lfsr_n    = puf_ch;
      word_n    = resp_word;
      ucnt_n    = unstable_cnt;
      ones_sum  = ones + VW'(resp_sync);
      maj       = (ones_sum > VW'(VOTES / 2));
      busy_n    = (state == ARM) || (state == LAUNCH) || (state == SAMPLE) || (state == ACC);
      done_n    = (state == DONE);
      puf_rst_n = (state == IDLE) || (state == ARM) || (state == DONE);
      puf_in_n  = ~puf_rst_n;

      case (state)
         IDLE: begin
            if (start) begin
               lfsr_n  = (seed == '0) ? SEED_ZERO_SUB : seed;
               cyc_n   = '0;
               vote_n  = '0;
               ones_n  = '0;
               bit_n   = '0;
               sh_n    = '0;
               unst_n  = '0;
               state_n = ARM;
            end
         end
         ARM: begin
            if (cyc_cnt == CW'(RST_CYC - 1)) begin
               cyc_n   = '0;
               state_n = LAUNCH;
            end else begin
               cyc_n = cyc_cnt + CW'(1);
            end
         end
         LAUNCH: begin
            if (cyc_cnt == CW'(SETTLE_CYC - 1)) begin
               cyc_n   = '0;
               state_n = SAMPLE;
            end else begin
               cyc_n = cyc_cnt + CW'(1);
            end
         end
         // Two extra cycles so the synchronizer holds the settled response.
         SAMPLE: begin
            if (cyc_cnt == CW'(1)) begin
               cyc_n   = '0;
               state_n = ACC;
            end else begin
               cyc_n = cyc_cnt + CW'(1);
            end
         end
         ACC: begin
            if (vote_cnt < VW'(VOTES - 1)) begin
               vote_n  = vote_cnt + VW'(1);
               ones_n  = ones_sum;
               state_n = ARM;
            end else begin
               sh_n = (shreg << 1) | RESP_BITS'(maj);
               if ((ones_sum != '0) && (ones_sum != VW'(VOTES))) begin
                  unst_n = unst + UW'(1);
               end
               lfsr_n  = lfsr_next(puf_ch);
               vote_n  = '0;
               ones_n  = '0;
               bit_n   = bit_idx + BW'(1);
               state_n = (bit_idx == BW'(RESP_BITS - 1)) ? DONE : ARM;
            end
         end
         DONE: begin
            word_n  = shreg;
            ucnt_n  = unst;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl at default parameters.
module tb_puf_eval_ctrl;

   localparam int NB  = 16;
   localparam int NV  = 5;
   localparam int T   = 4 + 16 + 3;
   localparam int LAT = NB * NV * T + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        start = 1'b0;
   logic [7:0]  seed = 8'h00;
   logic        busy, done;
   logic [15:0] resp_word;
   logic [4:0]  unstable_cnt;
   logic [7:0]  puf_ch;
   logic        puf_in, puf_rst;
   logic        puf_resp = 1'b0;

   int tests = 0;
   int fails = 0;

   // Responder configuration: mode 0 = table per launch, mode 1 = challenge LSB.
   int          resp_mode = 0;
   logic        vtab [NB*NV];
   int          launch_idx = 0;
   logic [7:0]  ch_obs [$];

   logic [7:0]  exp_ch [NB];
   logic [15:0] exp_word;
   int          exp_unst;

   puf_eval_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .seed         (seed),
      .busy         (busy),
      .done         (done),
      .resp_word    (resp_word),
      .unstable_cnt (unstable_cnt),
      .puf_ch       (puf_ch),
      .puf_in       (puf_in),
      .puf_rst      (puf_rst),
      .puf_resp     (puf_resp)
   );

   always #5 clk = ~clk;

   // PUF model: the response resolves at the launch edge; garbage while not launched.
   always @(posedge puf_in) begin
      ch_obs.push_back(puf_ch);
      if (resp_mode == 1)           puf_resp = puf_ch[0];
      else if (launch_idx < NB*NV)  puf_resp = vtab[launch_idx];
      else                          puf_resp = 1'b0;
      launch_idx++;
   end

   always @(negedge puf_in) puf_resp = 1'($urandom);

   function automatic logic [7:0] ref_lfsr(input logic [7:0] x);
      int v;
      v = int'(x) / 2;
      if (x[0]) v = v ^ 'hB8;
      return 8'(v);
   endfunction

   // Expected challenges, voted word and unstable count from the current responder setup.
   task automatic build_model(input logic [7:0] s);
      logic [7:0] c;
      int ones;
      c = (s == 8'h00) ? 8'h01 : s;
      exp_word = '0;
      exp_unst = 0;
      for (int b = 0; b < NB; b++) begin
         exp_ch[b] = c;
         ones = 0;
         for (int v = 0; v < NV; v++)
            ones += (resp_mode == 1) ? int'(c[0]) : int'(vtab[b*NV+v]);
         exp_word = {exp_word[14:0], (2 * ones > NV)};
         if (ones != 0 && ones != NV) exp_unst++;
         c = ref_lfsr(c);
      end
   endtask

   function automatic int ch_errors();
      int e;
      e = 0;
      if (ch_obs.size() != NB*NV) return NB*NV;
      for (int i = 0; i < NB*NV; i++)
         if (ch_obs[i] !== exp_ch[i/NV]) e++;
      return e;
   endfunction

   // Issue one request and wait (bounded) for done; extra_at > 0 pulses start mid-request.
   task automatic run_request(input logic [7:0] s, input int extra_at,
                              output int edges, output logic busy1, output logic busy_at_done);
      launch_idx = 0;
      ch_obs.delete();
      build_model(s);
      @(negedge clk);
      start = 1'b1;
      seed  = s;
      @(posedge clk);
      #1;
      start = 1'b0;
      seed  = 8'($urandom);
      edges = 0;
      busy1 = 1'b0;
      busy_at_done = 1'b1;
      while (edges < LAT + 200) begin
         @(posedge clk);
         #1;
         edges++;
         if (edges == 1) busy1 = busy;
         if (edges == extra_at) begin
            start = 1'b1;
            seed  = 8'hA5;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            busy_at_done = busy;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
      tests++; if (done !== 1'b0)         begin fails++; $display("FAIL rst_done: got %b expected 0", done); end
      tests++; if (resp_word !== 16'h0)   begin fails++; $display("FAIL rst_word: got %h expected 0000", resp_word); end
      tests++; if (unstable_cnt !== 5'd0) begin fails++; $display("FAIL rst_unst: got %0d expected 0", unstable_cnt); end
      tests++; if (puf_ch !== 8'h00)      begin fails++; $display("FAIL rst_ch: got %h expected 00", puf_ch); end
      tests++; if (puf_in !== 1'b0)       begin fails++; $display("FAIL rst_puf_in: got %b expected 0", puf_in); end
      tests++; if (puf_rst !== 1'b1)      begin fails++; $display("FAIL rst_puf_rst: got %b expected 1", puf_rst); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_all_ones();
      int e; logic b1, bd;
      resp_mode = 0;
      for (int i = 0; i < NB*NV; i++) vtab[i] = 1'b1;
      run_request(8'h01, 0, e, b1, bd);
      tests++; if (e !== LAT)               begin fails++; $display("FAIL ones_latency: got %0d expected %0d", e, LAT); end
      tests++; if (b1 !== 1'b1)             begin fails++; $display("FAIL ones_busy_rise: got %b expected 1", b1); end
      tests++; if (bd !== 1'b0)             begin fails++; $display("FAIL ones_busy_at_done: got %b expected 0", bd); end
      tests++; if (resp_word !== 16'hFFFF)  begin fails++; $display("FAIL ones_word: got %h expected ffff", resp_word); end
      tests++; if (unstable_cnt !== 5'd0)   begin fails++; $display("FAIL ones_unst: got %0d expected 0", unstable_cnt); end
      @(posedge clk); #1;
      tests++; if (done !== 1'b0)           begin fails++; $display("FAIL ones_done_pulse: got %b expected 0", done); end
   endtask

   task automatic test_ch_lsb();
      int e; logic b1, bd;
      logic [15:0] w;
      resp_mode = 1;
      run_request(8'h01, 0, e, b1, bd);
      w = resp_word;
      tests++; if (e !== LAT)                 begin fails++; $display("FAIL lsb_latency: got %0d expected %0d", e, LAT); end
      tests++; if (resp_word !== exp_word)    begin fails++; $display("FAIL lsb_word: got %h expected %h", resp_word, exp_word); end
      tests++; if (w[15:10] !== 6'b100011)    begin fails++; $display("FAIL lsb_word_top: got %b expected 100011", w[15:10]); end
      tests++; if (unstable_cnt !== 5'd0)     begin fails++; $display("FAIL lsb_unst: got %0d expected 0", unstable_cnt); end
      tests++; if (ch_errors() !== 0)         begin fails++; $display("FAIL lsb_ch_seq: got %0d bad challenges expected 0", ch_errors()); end
      tests++; if (ch_obs.size() < 6 || ch_obs[5] !== 8'hB8)
               begin fails++; $display("FAIL lsb_ch_second: got %h expected b8", (ch_obs.size() > 5) ? ch_obs[5] : 8'hxx); end
   endtask

   task automatic test_alternating();
      int e; logic b1, bd;
      resp_mode = 0;
      for (int i = 0; i < NB*NV; i++) vtab[i] = ((i % NV) % 2 == 0);
      run_request(8'h01, 0, e, b1, bd);
      tests++; if (resp_word !== 16'hFFFF)  begin fails++; $display("FAIL alt_word: got %h expected ffff", resp_word); end
      tests++; if (unstable_cnt !== 5'd16)  begin fails++; $display("FAIL alt_unst: got %0d expected 16", unstable_cnt); end
   endtask

   task automatic test_seed_zero();
      int e; logic b1, bd;
      resp_mode = 1;
      run_request(8'h00, 0, e, b1, bd);
      tests++; if (ch_obs.size() == 0 || ch_obs[0] !== 8'h01)
               begin fails++; $display("FAIL zero_first_ch: got %h expected 01", (ch_obs.size() > 0) ? ch_obs[0] : 8'hxx); end
      tests++; if (resp_word !== exp_word)  begin fails++; $display("FAIL zero_word: got %h expected %h", resp_word, exp_word); end
      tests++; if (unstable_cnt !== 5'd0)   begin fails++; $display("FAIL zero_unst: got %0d expected 0", unstable_cnt); end
   endtask

   task automatic test_start_ignored();
      int e, extra; logic b1, bd;
      resp_mode = 0;
      for (int i = 0; i < NB*NV; i++) vtab[i] = 1'($urandom);
      run_request(8'h3D, 100, e, b1, bd);
      tests++; if (e !== LAT)                begin fails++; $display("FAIL ign_latency: got %0d expected %0d", e, LAT); end
      tests++; if (ch_errors() !== 0)        begin fails++; $display("FAIL ign_ch_seq: got %0d bad challenges expected 0", ch_errors()); end
      tests++; if (resp_word !== exp_word)   begin fails++; $display("FAIL ign_word: got %h expected %h", resp_word, exp_word); end
      tests++; if (unstable_cnt !== 5'(exp_unst))
               begin fails++; $display("FAIL ign_unst: got %0d expected %0d", unstable_cnt, exp_unst); end
      extra = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (done || busy) extra++;
      end
      tests++; if (extra !== 0)              begin fails++; $display("FAIL ign_second_run: got %0d active cycles expected 0", extra); end
   endtask

   task automatic test_reset_mid();
      int e, k; logic b1, bd;
      resp_mode = 0;
      for (int i = 0; i < NB*NV; i++) vtab[i] = 1'($urandom);
      launch_idx = 0;
      @(negedge clk); start = 1'b1; seed = 8'h5A;
      @(negedge clk); start = 1'b0;
      k = 0;
      while (launch_idx < 5*NV + 1 && k < 3000) begin
         @(posedge clk);
         k++;
      end
      tests++; if (k >= 3000)  begin fails++; $display("FAIL mid_reach_bit5: got timeout expected launch of bit 5"); end
      repeat (3) @(negedge clk);
      tests++; if (puf_in !== 1'b1) begin fails++; $display("FAIL mid_in_launch: got %b expected 1", puf_in); end
      #2 rst = 1'b1;
      #1;
      tests++; if (puf_rst !== 1'b1)      begin fails++; $display("FAIL mid_puf_rst: got %b expected 1", puf_rst); end
      tests++; if (puf_in !== 1'b0)       begin fails++; $display("FAIL mid_puf_in: got %b expected 0", puf_in); end
      tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL mid_busy: got %b expected 0", busy); end
      tests++; if (resp_word !== 16'h0)   begin fails++; $display("FAIL mid_word: got %h expected 0000", resp_word); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      k = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done) k++;
      end
      tests++; if (k !== 0) begin fails++; $display("FAIL mid_no_done: got %0d done cycles expected 0", k); end
      for (int i = 0; i < NB*NV; i++) vtab[i] = 1'($urandom);
      run_request(8'hC3, 0, e, b1, bd);
      tests++; if (e !== LAT)               begin fails++; $display("FAIL mid_new_latency: got %0d expected %0d", e, LAT); end
      tests++; if (resp_word !== exp_word)  begin fails++; $display("FAIL mid_new_word: got %h expected %h", resp_word, exp_word); end
      tests++; if (unstable_cnt !== 5'(exp_unst))
               begin fails++; $display("FAIL mid_new_unst: got %0d expected %0d", unstable_cnt, exp_unst); end
      tests++; if (ch_errors() !== 0)       begin fails++; $display("FAIL mid_new_ch_seq: got %0d bad challenges expected 0", ch_errors()); end
   endtask

   task automatic test_random();
      int e, kind; logic b1, bd;
      logic [7:0] s;
      resp_mode = 0;
      for (int r = 0; r < 2; r++) begin
         s = 8'($urandom);
         for (int b = 0; b < NB; b++) begin
            kind = $urandom_range(0, 2);
            for (int v = 0; v < NV; v++)
               vtab[b*NV+v] = (kind == 0) ? 1'b0 : (kind == 1) ? 1'b1 : 1'($urandom);
         end
         run_request(s, 0, e, b1, bd);
         tests++; if (e !== LAT)               begin fails++; $display("FAIL rnd_latency: got %0d expected %0d", e, LAT); end
         tests++; if (resp_word !== exp_word)  begin fails++; $display("FAIL rnd_word: seed %h got %h expected %h", s, resp_word, exp_word); end
         tests++; if (unstable_cnt !== 5'(exp_unst))
                  begin fails++; $display("FAIL rnd_unst: seed %h got %0d expected %0d", s, unstable_cnt, exp_unst); end
         tests++; if (ch_errors() !== 0)       begin fails++; $display("FAIL rnd_ch_seq: seed %h got %0d bad challenges expected 0", s, ch_errors()); end
      end
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_ch_lsb();
      test_alternating();
      test_seed_zero();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
